// File: rtl/rmt_ctrl_pkg.sv
// rmt_ctrl_pkg: shared types and constants for the control-path arbiter.
package rmt_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, DROP} arb_state_t;
  typedef logic src_t;
  localparam logic TERM_TLAST = 1'b1;
  localparam logic TERM_TKEEP_BIT = 1'b0;
endpackage

// File: rtl/ctrl_arb_stall_timer.sv
// ctrl_arb_stall_timer: counts consecutive enabled cycles, pulses expire on the TIMEOUT_CYCLES-th one.
module ctrl_arb_stall_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  assign expire = enable && !clear && cnt == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset || clear || expire) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ctrl_path_arbiter.sv
// ctrl_path_arbiter: packet-atomic round-robin merge of two control streams onto a tready-less chain.
// Optional mid-packet stall timeout with terminator beat: define CTRL_ARB_TIMEOUT_EN.
module ctrl_path_arbiter
  import rmt_ctrl_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TIMEOUT_CYCLES       = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s0_axis_tuser,
  input  logic                                 s0_axis_tvalid,
  input  logic                                 s0_axis_tlast,
  output logic                                 s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s1_axis_tuser,
  input  logic                                 s1_axis_tvalid,
  input  logic                                 s1_axis_tlast,
  output logic                                 s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
  output logic                                 c_m_axis_tvalid,
  output logic                                 c_m_axis_tlast
);
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  arb_state_t state, state_nx;
  src_t g, g_nx;
  logic rr, rr_nx, vld_g, last_g, acc, emit, expire;
  assign vld_g = g ? s1_axis_tvalid : s0_axis_tvalid;
  assign last_g = g ? s1_axis_tlast : s0_axis_tlast;
`ifdef CTRL_ARB_TIMEOUT_EN
  ctrl_arb_stall_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_stall_timer (
    .clk(clk),
    .reset(reset),
    .clear(state != GRANT || acc),
    .enable(state == GRANT && !vld_g),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      g <= 1'b0;
      rr <= 1'b0;
    end else begin
      state <= state_nx;
      g <= g_nx;
      rr <= rr_nx;
    end
  always_comb begin
    state_nx = state;
    g_nx = g;
    rr_nx = rr;
    if (state == IDLE) begin
      if (s0_axis_tvalid || s1_axis_tvalid) begin
        state_nx = GRANT;
        g_nx = (s0_axis_tvalid && s1_axis_tvalid) ? rr : s1_axis_tvalid;
      end
    end else if (acc && last_g) begin
      state_nx = IDLE;
      rr_nx = ~g;
    end else if (expire) state_nx = DROP;
  end
  // DROP shares GRANT's handshake so the stalled packet's tail is absorbed
  always_comb begin
    s0_axis_tready = state != IDLE && !g;
    s1_axis_tready = state != IDLE && g;
    acc = state != IDLE && vld_g;
    emit = acc && state == GRANT;
  end
  always_ff @(posedge clk)
    if (reset) begin
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast <= 1'b0;
      c_m_axis_tdata <= '0;
      c_m_axis_tkeep <= '0;
      c_m_axis_tuser <= '0;
    end else if (expire) begin
      c_m_axis_tvalid <= 1'b1;
      c_m_axis_tlast <= TERM_TLAST;
      c_m_axis_tdata <= '0;
      c_m_axis_tkeep <= {KW{TERM_TKEEP_BIT}};
      c_m_axis_tuser <= '0;
    end else begin
      c_m_axis_tvalid <= emit;
      c_m_axis_tlast <= emit && last_g;
      if (emit) begin
        c_m_axis_tdata <= g ? s1_axis_tdata : s0_axis_tdata;
        c_m_axis_tkeep <= g ? s1_axis_tkeep : s0_axis_tkeep;
        c_m_axis_tuser <= g ? s1_axis_tuser : s0_axis_tuser;
      end
    end
endmodule

// File: tb/tb_ctrl_path_arbiter.sv
// tb_ctrl_path_arbiter: table-driven directed checks of ctrl_path_arbiter plus fairness/timeout sequences.
module tb_ctrl_path_arbiter;
  logic clk = 1'b0, reset;
  logic [511:0] s0_tdata, s1_tdata, m_tdata;
  logic [63:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic [127:0] s0_tuser, s1_tuser, m_tuser;
  logic s0_tvalid, s0_tlast, s0_tready, s1_tvalid, s1_tlast, s1_tready, m_tvalid, m_tlast;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  ctrl_path_arbiter #(.C_S_AXIS_DATA_WIDTH(512), .C_S_AXIS_TUSER_WIDTH(128), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tlast(s0_tlast), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tlast(s1_tlast), .s1_axis_tready(s1_tready),
    .c_m_axis_tdata(m_tdata), .c_m_axis_tkeep(m_tkeep), .c_m_axis_tuser(m_tuser),
    .c_m_axis_tvalid(m_tvalid), .c_m_axis_tlast(m_tlast)
  );
  typedef struct {
    logic rst, v0, l0;
    logic [7:0] d0;
    logic v1, l1;
    logic [7:0] d1;
    logic r0, r1, mv, ml, z;
    logic [7:0] md;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic rst, v0, l0, input logic [7:0] d0, input logic v1, l1,
                              input logic [7:0] d1, input logic r0, r1, mv, ml, z, input logic [7:0] md);
    vec_t t;
    t.rst = rst; t.v0 = v0; t.l0 = l0; t.d0 = d0; t.v1 = v1; t.l1 = l1; t.d1 = d1;
    t.r0 = r0; t.r1 = r1; t.mv = mv; t.ml = ml; t.z = z; t.md = md;
    return t;
  endfunction
  task automatic chk(input string n, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic drv(input logic v0, l0, input logic [7:0] d0, input logic v1, l1, input logic [7:0] d1);
    s0_tvalid = v0; s0_tlast = l0; s0_tdata = {64{d0}}; s0_tuser = {16{~d0}}; s0_tkeep = '1;
    s1_tvalid = v1; s1_tlast = l1; s1_tdata = {64{d1}}; s1_tuser = {16{~d1}}; s1_tkeep = '1;
  endtask
  task automatic chk_beat(input string n, input logic [7:0] d, input logic last);
    chk({n, "_valid"}, 512'(m_tvalid), 512'(1));
    chk({n, "_last"}, 512'(m_tlast), 512'(last));
    chk({n, "_data"}, m_tdata, {64{d}});
    chk({n, "_user"}, 512'(m_tuser), 512'({16{~d}}));
    chk({n, "_keep"}, 512'(m_tkeep), 512'({64{1'b1}}));
  endtask
  initial begin
    int n0, n1, k;
    logic [7:0] e;
    // rst | s0 v,l,d | s1 v,l,d | expect r0,r1,mv,ml,z,md
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0,1,8'h00));
    tbl.push_back(mk(0, 1,0,8'hA1, 0,0,8'h00, 0,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,0,8'hA1, 0,0,8'h00, 1,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,0,8'hA2, 0,0,8'h00, 1,0,1,0,0,8'hA1));
    tbl.push_back(mk(0, 1,1,8'hA3, 0,0,8'h00, 1,0,1,0,0,8'hA2));
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,1,1,0,8'hA3));
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0,0,8'h00));
    tbl.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 0,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,0,8'hB1, 1,0,8'hC1, 0,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,0,8'hB1, 1,0,8'hC1, 1,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,1,8'hB2, 1,0,8'hC1, 1,0,1,0,0,8'hB1));
    tbl.push_back(mk(0, 0,0,8'h00, 1,0,8'hC1, 0,0,1,1,0,8'hB2));
    tbl.push_back(mk(0, 0,0,8'h00, 1,0,8'hC1, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(0, 0,0,8'h00, 1,1,8'hC2, 0,1,1,0,0,8'hC1));
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,1,1,0,8'hC2));
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 0,0,8'h00, 1,0,8'hD1, 0,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,1,8'hE1, 1,0,8'hD1, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,1,8'hE1, 1,0,8'hD2, 0,1,1,0,0,8'hD1));
    tbl.push_back(mk(0, 1,1,8'hE1, 0,0,8'h00, 0,1,1,0,0,8'hD2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1,1,8'hE1, 0,0,8'h00, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,1,8'hE1, 1,0,8'hD3, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,1,8'hE1, 1,1,8'hD4, 0,1,1,0,0,8'hD3));
    tbl.push_back(mk(0, 1,1,8'hE1, 0,0,8'h00, 0,0,1,1,0,8'hD4));
    tbl.push_back(mk(0, 1,1,8'hE1, 0,0,8'h00, 1,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,1,1,0,8'hE1));
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,0,8'hF1, 0,0,8'h00, 0,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,0,8'hF1, 0,0,8'h00, 1,0,0,0,0,8'h00));
    tbl.push_back(mk(1, 1,0,8'hF2, 0,0,8'h00, 1,0,1,0,0,8'hF1));
    tbl.push_back(mk(0, 1,0,8'hF2, 1,1,8'h61, 0,0,0,0,1,8'h00));
    tbl.push_back(mk(0, 1,0,8'hF2, 1,1,8'h61, 1,0,0,0,0,8'h00));
    tbl.push_back(mk(0, 1,0,8'hF3, 1,1,8'h61, 1,0,1,0,0,8'hF2));
    tbl.push_back(mk(0, 1,1,8'hF4, 1,1,8'h61, 1,0,1,0,0,8'hF3));
    tbl.push_back(mk(0, 0,0,8'h00, 1,1,8'h61, 0,0,1,1,0,8'hF4));
    tbl.push_back(mk(0, 0,0,8'h00, 1,1,8'h61, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,1,1,0,8'h61));
    tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0,0,8'h00));
    reset = 1'b1;
    drv(0, 0, 8'h00, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("row%0d_s0_tready", i), 512'(s0_tready), 512'(tbl[i].r0));
      chk($sformatf("row%0d_s1_tready", i), 512'(s1_tready), 512'(tbl[i].r1));
      chk($sformatf("row%0d_tvalid", i), 512'(m_tvalid), 512'(tbl[i].mv));
      chk($sformatf("row%0d_tlast", i), 512'(m_tlast), 512'(tbl[i].ml));
      if (tbl[i].mv) chk_beat($sformatf("row%0d_beat", i), tbl[i].md, tbl[i].ml);
      if (tbl[i].z) begin
        chk($sformatf("row%0d_zero_data", i), m_tdata, '0);
        chk($sformatf("row%0d_zero_keep", i), 512'(m_tkeep), '0);
        chk($sformatf("row%0d_zero_user", i), 512'(m_tuser), '0);
      end
      reset = tbl[i].rst;
      drv(tbl[i].v0, tbl[i].l0, tbl[i].d0, tbl[i].v1, tbl[i].l1, tbl[i].d1);
    end
    // saturation: both sources offer single-beat packets, expect strict s0/s1 alternation
    n0 = 0; n1 = 0; k = 0;
    for (int c = 0; c < 100 && k < 20; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        e = k[0] ? (8'h80 | 8'(k / 2)) : 8'(k / 2);
        chk_beat($sformatf("fair%0d", k), e, 1'b1);
        k++;
      end
      drv(n0 < 10, 1'b1, 8'(n0), n1 < 10, 1'b1, 8'h80 | 8'(n1));
      if (s0_tready && s0_tvalid) n0++;
      if (s1_tready && s1_tvalid) n1++;
    end
    chk("fair_count", 512'(k), 512'(20));
    chk("fair_s0_count", 512'(n0), 512'(10));
    chk("fair_s1_count", 512'(n1), 512'(10));
`ifdef CTRL_ARB_TIMEOUT_EN
    @(negedge clk);
    drv(1, 0, 8'h31, 1, 1, 8'h51);
    @(negedge clk);
    chk("to_grant_s0", 512'(s0_tready), 512'(1));
    @(negedge clk);
    chk_beat("to_h1", 8'h31, 1'b0);
    drv(0, 0, 8'h00, 1, 1, 8'h51);
    repeat (7) begin
      @(negedge clk);
      chk("to_stall_novalid", 512'(m_tvalid), 512'(0));
      chk("to_stall_hold", 512'(s0_tready), 512'(1));
    end
    @(negedge clk);
    chk("to_term_valid", 512'(m_tvalid), 512'(1));
    chk("to_term_last", 512'(m_tlast), 512'(1));
    chk("to_term_keep", 512'(m_tkeep), '0);
    chk("to_term_data", m_tdata, '0);
    chk("to_term_user", 512'(m_tuser), '0);
    chk("to_drop_tready", 512'(s0_tready), 512'(1));
    drv(1, 0, 8'h32, 1, 1, 8'h51);
    @(negedge clk);
    chk("to_drop_h2", 512'(m_tvalid), 512'(0));
    drv(1, 1, 8'h33, 1, 1, 8'h51);
    @(negedge clk);
    chk("to_drop_h3", 512'(m_tvalid), 512'(0));
    chk("to_idle_s0", 512'(s0_tready), 512'(0));
    drv(0, 0, 8'h00, 1, 1, 8'h51);
    @(negedge clk);
    chk("to_grant_s1", 512'(s1_tready), 512'(1));
    @(negedge clk);
    chk_beat("to_j1", 8'h51, 1'b1);
    drv(0, 0, 8'h00, 0, 0, 8'h00);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
